// File: rtl/if_fetch_if.sv
// Instruction-memory channel between the fetch stage (master) and imem (slave):
// in-order requests with a ready handshake, responses that are never back-pressured.
interface if_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_fetch.sv
// RV64 instruction-fetch stage: credit-limited imem requests, return FIFO and output register.
// Optional IF_FETCH_PERF_EN adds saturating bubble/redirect counters.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        control_j,
  input  logic [63:0] pc_j,
  if_fetch_if.master  imem,
  output logic        pipe_valid,
  output logic [63:0] pipe_pc,
  output logic [31:0] pipe_data
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QD_SUM = (CW+1)'(QDEPTH);

  logic [63:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_dropCnt;

  logic [63:0]   r_pcqPc [QDEPTH];
  logic [PW-1:0] r_pcqWr;
  logic [PW-1:0] r_pcqRd;

  logic [63:0]   r_fqPc   [QDEPTH];
  logic [31:0]   r_fqInst [QDEPTH];
  logic [PW-1:0] r_fqWr;
  logic [PW-1:0] r_fqRd;
  logic [CW-1:0] r_fqCount;

  logic          r_pipeValid;
  logic [63:0]   r_pipePc;
  logic [31:0]   r_pipeData;

  logic [CW:0]   w_inFlight;
  logic          w_reqValid;
  logic          w_reqFire;
  logic          w_rspKeep;
  logic          w_outLoad;
  logic          w_fqEmpty;
  logic          w_fqPush;
  logic          w_fqPop;
  logic          w_bypass;
  logic [63:0]   w_rspPc;
  logic [63:0]   w_pcTarget;
  logic [CW-1:0] w_reqInc;
  logic [CW-1:0] w_rspDec;
  logic [CW-1:0] w_fqInc;
  logic [CW-1:0] w_fqDec;

  // Requests in flight plus buffered instructions never exceed the queue depth,
  // so every response that is kept always finds room in the FIFO.
  assign w_inFlight = {1'b0, r_outstanding} + {1'b0, r_fqCount};
  assign w_reqValid = !reset && !control_j && (w_inFlight < QD_SUM);
  assign w_reqFire  = w_reqValid && imem.imem_req_ready;

  assign imem.imem_req_valid = w_reqValid;
  assign imem.imem_req_addr  = r_pc;

  assign w_rspKeep  = imem.imem_rsp_valid && (r_dropCnt == '0) && !control_j;
  assign w_outLoad  = !stall || !r_pipeValid;
  assign w_fqEmpty  = (r_fqCount == '0);
  assign w_fqPop    = !control_j && w_outLoad && !w_fqEmpty;
  assign w_bypass   = w_rspKeep && w_fqEmpty && w_outLoad;
  assign w_fqPush   = w_rspKeep && !w_bypass;
  assign w_rspPc    = r_pcqPc[r_pcqRd];
  assign w_pcTarget = pc_j & ~64'h3;

  assign w_reqInc = CW'(w_reqFire);
  assign w_rspDec = CW'(imem.imem_rsp_valid);
  assign w_fqInc  = CW'(w_fqPush);
  assign w_fqDec  = CW'(w_fqPop);

  // On a redirect every request still in flight belongs to the wrong path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
    end else if (control_j) begin
      r_pc          <= w_pcTarget;
      r_outstanding <= r_outstanding - w_rspDec;
      r_dropCnt     <= r_outstanding - w_rspDec;
    end else begin
      if (w_reqFire) begin
        r_pc <= r_pc + 64'd4;
      end
      r_outstanding <= r_outstanding + w_reqInc - w_rspDec;
      if (imem.imem_rsp_valid && (r_dropCnt != '0)) begin
        r_dropCnt <= r_dropCnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcqWr <= '0;
      r_pcqRd <= '0;
    end else if (control_j) begin
      r_pcqWr <= '0;
      r_pcqRd <= '0;
    end else begin
      if (w_reqFire) begin
        r_pcqWr <= r_pcqWr + PW'(1);
      end
      if (w_rspKeep) begin
        r_pcqRd <= r_pcqRd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_reqFire) begin
      r_pcqPc[r_pcqWr] <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fqWr    <= '0;
      r_fqRd    <= '0;
      r_fqCount <= '0;
    end else if (control_j) begin
      r_fqWr    <= '0;
      r_fqRd    <= '0;
      r_fqCount <= '0;
    end else begin
      if (w_fqPush) begin
        r_fqWr <= r_fqWr + PW'(1);
      end
      if (w_fqPop) begin
        r_fqRd <= r_fqRd + PW'(1);
      end
      r_fqCount <= r_fqCount + w_fqInc - w_fqDec;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fqPush) begin
      r_fqPc[r_fqWr]   <= w_rspPc;
      r_fqInst[r_fqWr] <= imem.imem_rsp_data;
    end
  end

  // Buffered instructions are older than a same-cycle response, so the FIFO head wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipeValid <= 1'b0;
      r_pipePc    <= 64'h0;
      r_pipeData  <= NOP_INST;
    end else if (control_j) begin
      r_pipeValid <= 1'b0;
      r_pipeData  <= NOP_INST;
    end else if (w_outLoad) begin
      if (!w_fqEmpty) begin
        r_pipeValid <= 1'b1;
        r_pipePc    <= r_fqPc[r_fqRd];
        r_pipeData  <= r_fqInst[r_fqRd];
      end else if (w_bypass) begin
        r_pipeValid <= 1'b1;
        r_pipePc    <= w_rspPc;
        r_pipeData  <= imem.imem_rsp_data;
      end else begin
        r_pipeValid <= 1'b0;
        r_pipeData  <= NOP_INST;
      end
    end
  end

  assign pipe_valid = r_pipeValid;
  assign pipe_pc    = r_pipePc;
  assign pipe_data  = r_pipeData;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_bubbleCnt;
  logic [31:0] r_redirectCnt;
  logic        w_bubbleLoad;

  // A redirect reloads the output register with a NOP, so it counts as a bubble too.
  assign w_bubbleLoad = control_j || (w_outLoad && w_fqEmpty && !w_bypass);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubbleCnt   <= '0;
      r_redirectCnt <= '0;
    end else begin
      if (w_bubbleLoad && (r_bubbleCnt != '1)) begin
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
      end
      if (control_j && (r_redirectCnt != '1)) begin
        r_redirectCnt <= r_redirectCnt + 32'd1;
      end
    end
  end

  assign perf_bubble_cnt   = r_bubbleCnt;
  assign perf_redirect_cnt = r_redirectCnt;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: imem model returns inst = addr with 1- or 2-cycle latency.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        control_j;
  logic [63:0] pc_j;
  logic        pipeValid;
  logic [63:0] pipePc;
  logic [31:0] pipeData;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perfBubble;
  logic [31:0] perfRedirect;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int memLat = 1;

  logic        s1Valid;
  logic        s2Valid;
  logic [63:0] s1Addr;
  logic [63:0] s2Addr;

  logic [63:0] lat2Pc [8] = '{64'h0, 64'h0, 64'h0, 64'h4, 64'h4, 64'h8, 64'hC, 64'hC};
  logic        lat2V  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  if_fetch_if memIf ();

  always #5 clk = ~clk;

  // Memory resets together with the DUT; a two-stage delay line gives both latencies.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
      s1Addr  <= 64'h0;
      s2Addr  <= 64'h0;
    end else begin
      s1Valid <= memIf.imem_req_valid && memIf.imem_req_ready;
      s1Addr  <= memIf.imem_req_addr;
      s2Valid <= s1Valid;
      s2Addr  <= s1Addr;
    end
  end

  assign memIf.imem_rsp_valid = (memLat == 1) ? s1Valid : s2Valid;
  assign memIf.imem_rsp_data  = (memLat == 1) ? s1Addr[31:0] : s2Addr[31:0];

  if_fetch #(
    .RESET_PC (64'h0),
    .QDEPTH   (2),
    .NOP_INST (32'h00000013)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .control_j  (control_j),
    .pc_j       (pc_j),
    .imem       (memIf),
    .pipe_valid (pipeValid),
    .pipe_pc    (pipePc),
    .pipe_data  (pipeData)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_bubble_cnt   (perfBubble),
    .perf_redirect_cnt (perfRedirect)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkPipe(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] d);
    checkOutput({tag, ".valid"}, 64'(pipeValid), 64'(v));
    checkOutput({tag, ".pc"}, pipePc, pc);
    checkOutput({tag, ".data"}, 64'(pipeData), 64'(d));
  endtask

  task automatic checkReq(input string tag, input logic v, input logic [63:0] addr);
    checkOutput({tag, ".reqValid"}, 64'(memIf.imem_req_valid), 64'(v));
    if (v) begin
      checkOutput({tag, ".reqAddr"}, memIf.imem_req_addr, addr);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic cj, input logic [63:0] pj, input logic rdy);
    stall                 = s;
    control_j             = cj;
    pc_j                  = pj;
    memIf.imem_req_ready  = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkPipe("rst", 1'b0, 64'h0, 32'h13);
    checkOutput("rst.reqValid", 64'(memIf.imem_req_valid), 64'h0);

    // Zero-wait streaming: one instruction per cycle starting two edges after release.
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) nextCycle();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      #1;
      checkReq($sformatf("seq%0d", n), 1'b1, 64'(4 * n));
      if (n >= 2) checkPipe($sformatf("seq%0d", n), 1'b1, 64'(4 * (n - 2)), 32'(4 * (n - 2)));
      else        checkPipe($sformatf("seq%0d", n), 1'b0, 64'h0, 32'h13);
    end

    // Stall for five edges: one more request, then credits run out with 24 and 28 buffered.
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    #1;
    checkReq("stall0", 1'b1, 64'd28);
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      applyStimulus((k < 5), 1'b0, 64'h0, 1'b1);
      #1;
      checkPipe($sformatf("stall%0d", k), 1'b1, 64'd20, 32'd20);
      checkOutput($sformatf("stall%0d.reqValid", k), 64'(memIf.imem_req_valid), 64'h0);
    end
    for (int j = 0; j < 5; j++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      #1;
      checkPipe($sformatf("resume%0d", j), 1'b1, 64'(24 + 4 * j), 32'(24 + 4 * j));
    end

    // Memory not ready for three cycles: address holds at 48, output drains to bubbles.
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    checkReq("rdy0", 1'b1, 64'd48);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b0); #1;
    checkReq("rdy1", 1'b1, 64'd48);
    checkPipe("rdy1", 1'b1, 64'd44, 32'd44);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b0); #1;
    checkReq("rdy2", 1'b1, 64'd48);
    checkPipe("rdy2", 1'b0, 64'd44, 32'h13);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkReq("rdy3", 1'b1, 64'd48);
    checkPipe("rdy3", 1'b0, 64'd44, 32'h13);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkReq("rdy4", 1'b1, 64'd52);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("rdy5", 1'b1, 64'd48, 32'd48);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("rdy6", 1'b1, 64'd52, 32'd52);
    checkReq("rdy6", 1'b1, 64'd60);

    // Redirect together with stall and the response for 56; pc_j low bits are ignored.
    applyStimulus(1'b1, 1'b1, 64'h201, 1'b1);
    #1;
    checkOutput("jStall.reqValid", 64'(memIf.imem_req_valid), 64'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("jStall1", 1'b0, 64'd52, 32'h13);
    checkReq("jStall1", 1'b1, 64'h200);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("jStall2", 1'b0, 64'd52, 32'h13);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("jStall3", 1'b1, 64'h200, 32'h200);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("jStall4", 1'b1, 64'h204, 32'h204);

    reset = 1'b1;
    #1;
    checkPipe("rst2", 1'b0, 64'h0, 32'h13);
    memLat = 2;
    nextCycle();
    nextCycle();
    reset = 1'b0;

    // Two-cycle memory: credits allow at most two requests in flight.
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    checkReq("lat2.0", 1'b1, 64'h0);
    for (int n = 1; n <= 8; n++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      #1;
      checkPipe($sformatf("lat2.%0d", n), lat2V[n-1], lat2Pc[n-1],
                lat2V[n-1] ? lat2Pc[n-1][31:0] : 32'h13);
    end
    checkOutput("lat2.8.reqValid", 64'(memIf.imem_req_valid), 64'h0);

    // Redirect with 16 and 20 outstanding: 16 is dropped now, 20 when it returns.
    applyStimulus(1'b0, 1'b1, 64'h100, 1'b1);
    #1;
    checkOutput("j2.reqValid", 64'(memIf.imem_req_valid), 64'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("j2.1", 1'b0, 64'd12, 32'h13);
    checkReq("j2.1", 1'b1, 64'h100);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("j2.2", 1'b0, 64'd12, 32'h13);
    checkReq("j2.2", 1'b1, 64'h104);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("j2.3", 1'b0, 64'd12, 32'h13);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("j2.4", 1'b1, 64'h100, 32'h100);
    checkReq("j2.4", 1'b1, 64'h108);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("j2.5", 1'b1, 64'h104, 32'h104);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkOutput("j2.6.reqValid", 64'(memIf.imem_req_valid), 64'h0);

    // Mid-cycle reset with 0x108 and 0x10c outstanding must clear outputs without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    checkPipe("rstMid", 1'b0, 64'h0, 32'h13);
    checkOutput("rstMid.reqValid", 64'(memIf.imem_req_valid), 64'h0);
    checkOutput("rstMid.reqAddr", memIf.imem_req_addr, 64'h0);
`ifdef IF_FETCH_PERF_EN
    checkOutput("rstMid.perfBubble", 64'(perfBubble), 64'h0);
    checkOutput("rstMid.perfRedirect", 64'(perfRedirect), 64'h0);
`endif
    memLat = 1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkReq("restart0", 1'b1, 64'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkReq("restart1", 1'b1, 64'h4);
    nextCycle(); applyStimulus(1'b0, 1'b0, 64'h0, 1'b1); #1;
    checkPipe("restart2", 1'b1, 64'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
